// File: rtl/mips_core_pkg.sv
// Types and constants shared by the AXI read and write schedulers.
// Holds the scheduler FSM encoding and the fixed AXI length/ID widths.
package mips_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } sched_state_e;

    localparam int AXI_LEN_W = 4;
    localparam int AXI_ID_W  = 4;

endpackage

// File: rtl/axi_read_scheduler_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr_i, with wrap.
// Produces a one-hot grant, its index and a valid flag.
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    int   cand;
    logic found;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        found       = 1'b0;
        cand        = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr_i) + off) % N;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = IDX_W'(cand);
                gnt_valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_scheduler.sv
// Round-robin owner of the shared AXI read channel: one burst in flight, ARID = owner,
// R beats steered back combinationally, sticky proto_err on stray or mis-sized bursts.
module axi_read_scheduler
    import mips_core_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS*AXI_LEN_W-1:0]  m_arlen,
    output logic [NUM_MASTERS-1:0]            m_arready,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [NUM_MASTERS-1:0]            m_rlast,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              ARVALID,
    input  logic                              ARREADY,
    output logic [AXI_ID_W-1:0]               ARID,
    output logic [AXI_LEN_W-1:0]              ARLEN,
    output logic [ADDR_WIDTH-1:0]             ARADDR,
    input  logic                              RVALID,
    input  logic                              RLAST,
    input  logic [AXI_ID_W-1:0]               RID,
    input  logic [DATA_WIDTH-1:0]             RDATA,
    output logic                              RREADY,
    output logic                              busy,
    output logic                              proto_err
);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic [AXI_LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                   perr_q, perr_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   beat_hit;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i       (m_arvalid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (pick_gnt),
        .gnt_idx_o   (pick_idx),
        .gnt_valid_o (pick_valid)
    );

    assign beat_hit = (state_q == DATA) && RVALID && (RID == AXI_ID_W'(owner_q));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            perr_q     <= perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        perr_d     = perr_q;

        // A beat is only legitimate while a burst is being collected.
        if (RVALID && (state_q != DATA)) begin
            perr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ADDR;
                    owner_d = pick_idx;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (pick_gnt[i]) begin
                            addr_d = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            len_d  = m_arlen[i*AXI_LEN_W +: AXI_LEN_W];
                        end
                    end
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat_hit) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (RLAST) begin
                        if (beat_cnt_q != len_q) begin
                            perr_d = 1'b1;
                        end
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                    end else if (beat_cnt_q == '1) begin
                        perr_d = 1'b1;
                    end
                end else if (RVALID) begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ARVALID   = (state_q == ADDR);
        RREADY    = (state_q == DATA);
        busy      = (state_q != IDLE);
        ARID      = AXI_ID_W'(owner_q);
        ARLEN     = len_q;
        ARADDR    = addr_q;
        proto_err = perr_q;
        m_rdata   = beat_hit ? RDATA : '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == IDX_W'(i)) begin
                m_arready[i] = (state_q == ADDR) && ARREADY;
                m_rvalid[i]  = beat_hit;
                m_rlast[i]   = beat_hit && RLAST;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Self-checking bench for axi_read_scheduler: drives AR/R traffic by hand and
// checks forwarded beats against a scoreboard and a small arbitration/error model.
module tb_axi_read_scheduler;

    localparam int NM = 3;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [NM-1:0] m_arvalid;
    logic [NM*AW-1:0] m_araddr;
    logic [NM*4-1:0]  m_arlen;
    logic [NM-1:0] m_arready;
    logic [NM-1:0] m_rvalid;
    logic [NM-1:0] m_rlast;
    logic [DW-1:0] m_rdata;
    logic          ARVALID;
    logic          ARREADY;
    logic [3:0]    ARID;
    logic [3:0]    ARLEN;
    logic [AW-1:0] ARADDR;
    logic          RVALID;
    logic          RLAST;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA;
    logic          RREADY;
    logic          busy;
    logic          proto_err;

    axi_read_scheduler #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rdata   (m_rdata),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARID      (ARID),
        .ARLEN     (ARLEN),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RLAST     (RLAST),
        .RID       (RID),
        .RDATA     (RDATA),
        .RREADY    (RREADY),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model of the scheduler's visible state.
    int         model_ptr;
    bit         in_data;
    int         cur_owner;
    logic [3:0] cur_len;
    int         cnt;
    logic       exp_perr;

    task automatic apply_reset();
        rst_n     = 1'b0;
        m_arvalid = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RID       = '0;
        RDATA     = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = 0;
        in_data   = 1'b0;
        cur_owner = 0;
        cur_len   = '0;
        cnt       = 0;
        exp_perr  = 1'b0;
        sb.delete();
    endtask

    task automatic req(input int m, input logic [AW-1:0] a, input logic [3:0] l);
        m_arvalid[m]       = 1'b1;
        m_araddr[m*AW +: AW] = a;
        m_arlen[m*4 +: 4]  = l;
    endtask

    // Waits (bounded) for ARVALID, checks the address phase, stalls ARREADY, then handshakes.
    task automatic expect_grant(input int m, input logic [AW-1:0] a, input logic [3:0] l,
                                input int stall, input bit drop);
        logic [NM-1:0] exp_oh;
        exp_oh = '0;
        exp_oh[m] = 1'b1;
        for (int i = 0; i < 10 && ARVALID !== 1'b1; i++) @(negedge clk);
        vectors++;
        if (ARVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL arvalid_timeout: ARVALID=%b required 1", ARVALID);
        end
        vectors++;
        if (ARID !== 4'(m) || ARADDR !== a || ARLEN !== l) begin
            miscompares++;
            $display("FAIL ar_fields: ARID=%0d ARADDR=%h ARLEN=%0d required %0d %h %0d",
                     ARID, ARADDR, ARLEN, m, a, l);
        end
        for (int s = 0; s < stall; s++) begin
            ARREADY = 1'b0;
            #1;
            vectors++;
            if (ARVALID !== 1'b1 || ARID !== 4'(m) || ARADDR !== a || ARLEN !== l
                || m_arready !== '0) begin
                miscompares++;
                $display("FAIL ar_stall[%0d]: ARVALID=%b ARID=%0d ARADDR=%h m_arready=%b required 1 %0d %h 000",
                         s, ARVALID, ARID, ARADDR, m_arready, m, a);
            end
            @(negedge clk);
        end
        ARREADY = 1'b1;
        #1;
        vectors++;
        if (m_arready !== exp_oh) begin
            miscompares++;
            $display("FAIL m_arready_pulse: got %b required %b", m_arready, exp_oh);
        end
        @(negedge clk);
        ARREADY = 1'b0;
        if (drop) m_arvalid[m] = 1'b0;
        in_data   = 1'b1;
        cur_owner = m;
        cur_len   = l;
        cnt       = 0;
        #1;
        vectors++;
        if (m_arready !== '0 || RREADY !== 1'b1 || ARVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL data_entry: m_arready=%b RREADY=%b ARVALID=%b required 000 1 0",
                     m_arready, RREADY, ARVALID);
        end
    endtask

    // Drives one R beat for a cycle; checks forwarding via the scoreboard and proto_err after the edge.
    task automatic send_beat(input logic [3:0] id, input logic [31:0] data, input logic last);
        bit            fwd;
        beat_t         e;
        logic [NM-1:0] oh;
        fwd    = in_data && (int'(id) == cur_owner);
        RVALID = 1'b1;
        RID    = id;
        RDATA  = data;
        RLAST  = last;
        if (fwd) sb.push_back('{cur_owner, data, last});
        #1;
        vectors++;
        if (|m_rvalid) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: m_rvalid=%b m_rdata=%h required no beat", m_rvalid, m_rdata);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.m] = 1'b1;
                if (m_rvalid !== oh || m_rdata !== e.data || m_rlast !== (e.last ? oh : '0)) begin
                    miscompares++;
                    $display("FAIL beat_data: m_rvalid=%b m_rlast=%b m_rdata=%h required %b %b %h",
                             m_rvalid, m_rlast, m_rdata, oh, e.last ? oh : '0, e.data);
                end
            end
        end else if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL beat_missing: m_rvalid=%b required beat for master %0d", m_rvalid, sb[0].m);
            sb.delete();
        end
        if (!fwd) begin
            exp_perr = 1'b1;
        end else begin
            if (last) begin
                if (cnt != int'(cur_len)) exp_perr = 1'b1;
                in_data   = 1'b0;
                model_ptr = (cur_owner + 1) % NM;
            end else if (cnt == 15) begin
                exp_perr = 1'b1;
            end
            cnt = (cnt + 1) % 16;
        end
        @(negedge clk);
        RVALID = 1'b0;
        RLAST  = 1'b0;
        vectors++;
        if (proto_err !== exp_perr) begin
            miscompares++;
            $display("FAIL proto_err: got %b required %b", proto_err, exp_perr);
        end
    endtask

    task automatic check_idle(input string name);
        #1;
        vectors++;
        if (busy !== 1'b0 || ARVALID !== 1'b0 || RREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: busy=%b ARVALID=%b RREADY=%b required 0 0 0", name, busy, ARVALID, RREADY);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY, busy, proto_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b ARVALID=%b ARADDR=%h m_rdata=%h proto_err=%b required all 0",
                     busy, ARVALID, ARADDR, m_rdata, proto_err);
        end
        apply_reset();
        check_idle("reset_release");
    endtask

    task automatic test_single();
        req(1, 26'h0000100, 4'd3);
        #1;
        vectors++;
        if (ARVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL grant_latency_early: ARVALID=%b required 0", ARVALID);
        end
        @(negedge clk);
        vectors++;
        if (ARVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL grant_latency: ARVALID=%b required 1", ARVALID);
        end
        expect_grant(1, 26'h0000100, 4'd3, 0, 1'b1);
        for (int b = 0; b < 4; b++) send_beat(4'd1, 32'hA000_0000 + 32'(b), b == 3);
        check_idle("single_done");
    endtask

    task automatic test_round_robin();
        int order[4] = '{0, 1, 2, 0};
        apply_reset();
        for (int m = 0; m < NM; m++) req(m, 26'(32'h1000 * (m + 1)), 4'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) check_idle("rr_gap");
            expect_grant(order[k], 26'(32'h1000 * (order[k] + 1)), 4'd1, 0, 1'b0);
            send_beat(4'(order[k]), 32'hB000_0000 + 32'(k * 2), 1'b0);
            send_beat(4'(order[k]), 32'hB000_0001 + 32'(k * 2), 1'b1);
        end
        m_arvalid = '0;
        @(negedge clk);
        check_idle("rr_end");
    endtask

    task automatic test_ar_stall();
        req(0, 26'h3FF_FFC0, 4'd0);
        expect_grant(0, 26'h3FF_FFC0, 4'd0, 5, 1'b1);
        send_beat(4'd0, 32'hC0DE_0001, 1'b1);
        check_idle("stall_done");
    endtask

    task automatic test_rid_mismatch();
        req(0, 26'h0000200, 4'd2);
        expect_grant(0, 26'h0000200, 4'd2, 0, 1'b1);
        send_beat(4'd2, 32'hDEAD_BEEF, 1'b0);
        for (int b = 0; b < 3; b++) send_beat(4'd0, 32'hD000_0000 + 32'(b), b == 2);
        check_idle("rid_done");
    endtask

    task automatic test_short_burst();
        req(1, 26'h0000300, 4'd3);
        expect_grant(1, 26'h0000300, 4'd3, 0, 1'b1);
        send_beat(4'd1, 32'hE000_0000, 1'b0);
        send_beat(4'd1, 32'hE000_0001, 1'b1);
        check_idle("short_done");
    endtask

    task automatic test_reset_mid_burst();
        req(0, 26'h0000400, 4'd3);
        expect_grant(0, 26'h0000400, 4'd3, 0, 1'b1);
        send_beat(4'd0, 32'hF000_0000, 1'b0);
        send_beat(4'd0, 32'hF000_0001, 1'b0);
        RVALID = 1'b1;
        RID    = 4'd0;
        RDATA  = 32'hF000_0002;
        rst_n  = 1'b0;
        #1;
        vectors++;
        if ({m_arready, m_rvalid, m_rlast, m_rdata, ARVALID, ARID, ARLEN, ARADDR, RREADY, busy, proto_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: m_rvalid=%b m_rdata=%h RREADY=%b busy=%b proto_err=%b required all 0",
                     m_rvalid, m_rdata, RREADY, busy, proto_err);
        end
        RVALID = 1'b0;
        apply_reset();
        req(2, 26'h2AB_CDE0, 4'd0);
        expect_grant(2, 26'h2AB_CDE0, 4'd0, 0, 1'b1);
        send_beat(4'd2, 32'h1234_5678, 1'b1);
        check_idle("post_reset_done");
    endtask

    task automatic test_stray_beat();
        send_beat(4'd1, 32'h5555_AAAA, 1'b1);
        check_idle("stray_idle");
    endtask

    initial begin
        rst_n     = 1'b0;
        m_arvalid = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RID       = '0;
        RDATA     = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_ar_stall();
        test_rid_mismatch();
        test_short_burst();
        test_reset_mid_burst();
        test_stray_beat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
